countdown_timer_ctrl: RTL and testbench

Parametrised mm:ss countdown timer controller for the microwave/fryer control path, successor to the single-mode timer counter. Adds load/run/pause/cancel control, in-flight time adjust with carry/borrow and saturation, a configurable minute range, and a held alarm phase after expiry. Ticks once per `clk_1Hz` edge. Feeds the 7-segment display driver and the heater/alarm control logic.

---
 rtl/timer_pkg.sv | 18 +
 rtl/mmss_adjust.sv | 64 ++++++
 rtl/countdown_timer_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_countdown_timer_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// timer_pkg
// Shared definitions for the mm:ss countdown timer controller.
//   state_t : controller state (IDLE, RUN, PAUSE, DONE)
//   SEC_MAX : largest seconds value shown on the display
//   SEC_W   : width of the seconds field
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int SEC_MAX = 59;
    localparam int SEC_W   = 6;

endpackage

// File: rtl/mmss_adjust.sv
// mmss_adjust
// Combinational add/subtract of STEP_S seconds on an mm:ss value.
// Addition carries into minutes and saturates at MAX_MIN:59.
// Subtraction borrows from minutes and floors at 0:00.
// Ports:
//   min_in  : current minutes
//   sec_in  : current seconds (0..59)
//   sub     : 1 = subtract STEP_S, 0 = add STEP_S
//   min_out : adjusted minutes
//   sec_out : adjusted seconds
module mmss_adjust
    import timer_pkg::*;
#(
    parameter int MIN_W   = 7,
    parameter int MAX_MIN = 99,
    parameter int STEP_S  = 30
) (
    input  logic [MIN_W-1:0] min_in,
    input  logic [SEC_W-1:0] sec_in,
    input  logic             sub,
    output logic [MIN_W-1:0] min_out,
    output logic [SEC_W-1:0] sec_out
);

    localparam logic [MIN_W-1:0] MAX_MIN_V = MIN_W'(MAX_MIN);
    localparam logic [SEC_W-1:0] SEC_MAX_V = SEC_W'(SEC_MAX);

    // One extra bit so that 59 + 59 fits without wrapping.
    logic [SEC_W:0] sec_wide;

    always_comb begin
        min_out  = min_in;
        sec_out  = sec_in;
        sec_wide = '0;
        if (!sub) begin
            sec_wide = {1'b0, sec_in} + (SEC_W+1)'(STEP_S);
            if (sec_wide >= (SEC_W+1)'(60)) begin
                // Carry needed; if minutes are already at the top, pin to MAX_MIN:59.
                if (min_in >= MAX_MIN_V) begin
                    min_out = MAX_MIN_V;
                    sec_out = SEC_MAX_V;
                end else begin
                    min_out = min_in + MIN_W'(1);
                    sec_out = SEC_W'(sec_wide - (SEC_W+1)'(60));
                end
            end else begin
                sec_out = sec_wide[SEC_W-1:0];
            end
        end else begin
            if (sec_in >= SEC_W'(STEP_S)) begin
                sec_out = sec_in - SEC_W'(STEP_S);
            end else if (min_in == '0) begin
                // Nothing left to borrow from: floor at zero.
                min_out = '0;
                sec_out = '0;
            end else begin
                sec_wide = {1'b0, sec_in} + (SEC_W+1)'(60 - STEP_S);
                min_out  = min_in - MIN_W'(1);
                sec_out  = sec_wide[SEC_W-1:0];
            end
        end
    end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// countdown_timer_ctrl
// mm:ss countdown timer with load/run/pause/cancel control, in-flight
// adjust by STEP_S seconds, and a held alarm phase after expiry.
// Ports:
//   clk_1Hz    : timer clock, one count per rising edge
//   rst        : asynchronous active-low reset
//   load       : capture minutes_in/seconds_in (saturated)
//   minutes_in : preset minutes
//   seconds_in : preset seconds
//   start      : start or resume (also ends the alarm)
//   pause      : hold the count
//   cancel     : abort, clear to 0:00
//   increment  : add STEP_S seconds
//   decrement  : subtract STEP_S seconds
//   minutes    : current minutes
//   seconds    : current seconds
//   running    : high in RUN
//   paused     : high in PAUSE
//   timer_end  : one-cycle pulse on entering DONE
//   alarm      : high while in DONE
module countdown_timer_ctrl
    import timer_pkg::*;
#(
    parameter int MIN_W        = 7,
    parameter int MAX_MIN      = 99,
    parameter int STEP_S       = 30,
    parameter int ALARM_CYCLES = 3
) (
    input  logic             clk_1Hz,
    input  logic             rst,
    input  logic             load,
    input  logic [MIN_W-1:0] minutes_in,
    input  logic [SEC_W-1:0] seconds_in,
    input  logic             start,
    input  logic             pause,
    input  logic             cancel,
    input  logic             increment,
    input  logic             decrement,
    output logic [MIN_W-1:0] minutes,
    output logic [SEC_W-1:0] seconds,
    output logic             running,
    output logic             paused,
    output logic             timer_end,
    output logic             alarm
);

    localparam logic [MIN_W-1:0] MAX_MIN_V  = MIN_W'(MAX_MIN);
    localparam logic [SEC_W-1:0] SEC_MAX_V  = SEC_W'(SEC_MAX);
    localparam logic [3:0]       ALARM_LAST = 4'(ALARM_CYCLES - 1);

    state_t           state;
    logic [3:0]       alarm_cnt;
    logic [MIN_W-1:0] adj_min;
    logic [SEC_W-1:0] adj_sec;
    logic [MIN_W-1:0] load_min;
    logic [SEC_W-1:0] load_sec;
    logic             count_zero;
    logic             adj_zero;
    logic             adjust;

    // Increment outranks decrement, so subtraction is selected only when increment is low.
    mmss_adjust #(
        .MIN_W   (MIN_W),
        .MAX_MIN (MAX_MIN),
        .STEP_S  (STEP_S)
    ) u_adjust (
        .min_in  (minutes),
        .sec_in  (seconds),
        .sub     (~increment),
        .min_out (adj_min),
        .sec_out (adj_sec)
    );

    always_comb begin
        load_min   = (minutes_in > MAX_MIN_V) ? MAX_MIN_V : minutes_in;
        load_sec   = (seconds_in > SEC_MAX_V) ? SEC_MAX_V : seconds_in;
        count_zero = (minutes == '0) && (seconds == '0);
        adj_zero   = (adj_min == '0) && (adj_sec == '0);
        adjust     = increment | decrement;
    end

    assign running = (state == RUN);
    assign paused  = (state == PAUSE);

    // Controller FSM. Cancel and load act in every state; the remaining
    // controls are evaluated per state in priority order, and only the first
    // one present takes effect. timer_end defaults low so it pulses once.
    always_ff @(posedge clk_1Hz or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            minutes   <= '0;
            seconds   <= '0;
            alarm_cnt <= '0;
            timer_end <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            timer_end <= 1'b0;
            if (cancel) begin
                state     <= IDLE;
                minutes   <= '0;
                seconds   <= '0;
                alarm_cnt <= '0;
                alarm     <= 1'b0;
            end else if (load) begin
                state     <= IDLE;
                minutes   <= load_min;
                seconds   <= load_sec;
                alarm_cnt <= '0;
                alarm     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (pause) begin
                            state <= IDLE;
                        end else if (start) begin
                            if (!count_zero) state <= RUN;
                        end else if (adjust) begin
                            minutes <= adj_min;
                            seconds <= adj_sec;
                        end
                    end
                    RUN: begin
                        if (pause) begin
                            state <= PAUSE;
                        end else if (start) begin
                            state <= RUN;
                        end else if (adjust) begin
                            minutes <= adj_min;
                            seconds <= adj_sec;
                            if (adj_zero) begin
                                state     <= DONE;
                                timer_end <= 1'b1;
                                alarm     <= 1'b1;
                                alarm_cnt <= '0;
                            end
                        end else if (seconds != '0) begin
                            seconds <= seconds - SEC_W'(1);
                            if ((minutes == '0) && (seconds == SEC_W'(1))) begin
                                state     <= DONE;
                                timer_end <= 1'b1;
                                alarm     <= 1'b1;
                                alarm_cnt <= '0;
                            end
                        end else if (minutes != '0) begin
                            seconds <= SEC_MAX_V;
                            minutes <= minutes - MIN_W'(1);
                        end else begin
                            state     <= DONE;
                            timer_end <= 1'b1;
                            alarm     <= 1'b1;
                            alarm_cnt <= '0;
                        end
                    end
                    PAUSE: begin
                        if (pause) begin
                            state <= PAUSE;
                        end else if (start) begin
                            state <= RUN;
                        end else if (adjust) begin
                            minutes <= adj_min;
                            seconds <= adj_sec;
                            if (adj_zero) state <= IDLE;
                        end
                    end
                    DONE: begin
                        if (start || (alarm_cnt == ALARM_LAST)) begin
                            state     <= IDLE;
                            minutes   <= '0;
                            seconds   <= '0;
                            alarm_cnt <= '0;
                            alarm     <= 1'b0;
                        end else begin
                            alarm_cnt <= alarm_cnt + 4'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// tb_countdown_timer_ctrl
// Directed self-checking bench for countdown_timer_ctrl with default
// parameters (MIN_W=7, MAX_MIN=99, STEP_S=30, ALARM_CYCLES=3).
module tb_countdown_timer_ctrl;

    localparam logic [5:0] C_NONE   = 6'b000000;
    localparam logic [5:0] C_DEC    = 6'b000001;
    localparam logic [5:0] C_INC    = 6'b000010;
    localparam logic [5:0] C_START  = 6'b000100;
    localparam logic [5:0] C_PAUSE  = 6'b001000;
    localparam logic [5:0] C_LOAD   = 6'b010000;
    localparam logic [5:0] C_CANCEL = 6'b100000;

    logic       clk_1Hz = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic [6:0] minutes_in = '0;
    logic [5:0] seconds_in = '0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       cancel = 1'b0;
    logic       increment = 1'b0;
    logic       decrement = 1'b0;
    logic [6:0] minutes;
    logic [5:0] seconds;
    logic       running;
    logic       paused;
    logic       timer_end;
    logic       alarm;

    int checks = 0;
    int errors = 0;

    countdown_timer_ctrl dut (
        .clk_1Hz    (clk_1Hz),
        .rst        (rst),
        .load       (load),
        .minutes_in (minutes_in),
        .seconds_in (seconds_in),
        .start      (start),
        .pause      (pause),
        .cancel     (cancel),
        .increment  (increment),
        .decrement  (decrement),
        .minutes    (minutes),
        .seconds    (seconds),
        .running    (running),
        .paused     (paused),
        .timer_end  (timer_end),
        .alarm      (alarm)
    );

    // Free-running timer clock, 10 time units per period.
    always #5 clk_1Hz = ~clk_1Hz;

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one cycle of controls, let a rising edge sample them, then
    // settle 1 unit past the edge so outputs are read away from it.
    task automatic applyStimulus(input logic [5:0] ctl, input logic [6:0] mi, input logic [5:0] si);
        {cancel, load, pause, start, increment, decrement} = ctl;
        minutes_in = mi;
        seconds_in = si;
        @(posedge clk_1Hz);
        #1;
        {cancel, load, pause, start, increment, decrement} = C_NONE;
    endtask

    // Compare every output against hand-computed values in one assertion.
    task automatic checkOutput(input string tag, input logic [6:0] em, input logic [5:0] es,
                               input logic er, input logic ep, input logic ete, input logic eal);
        logic [16:0] obs;
        logic [16:0] exp;
        obs = {minutes, seconds, running, paused, timer_end, alarm};
        exp = {em, es, er, ep, ete, eal};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got %0d:%0d run=%b pau=%b end=%b alm=%b, expected %0d:%0d run=%b pau=%b end=%b alm=%b",
                   tag, minutes, seconds, running, paused, timer_end, alarm, em, es, er, ep, ete, eal);
        end
    endtask

    // Directed sequence of steps with expected values worked out by hand.
    initial begin
        $display("[TB] start");
        #2;
        checkOutput("reset_state", 7'd0, 6'd0, 0, 0, 0, 0);
        #1 rst = 1'b1;

        applyStimulus(C_START, 7'd0, 6'd0);
        checkOutput("start_at_zero", 7'd0, 6'd0, 0, 0, 0, 0);

        applyStimulus(C_LOAD, 7'd1, 6'd2);
        checkOutput("load_1_02", 7'd1, 6'd2, 0, 0, 0, 0);
        applyStimulus(C_START, 7'd0, 6'd0);
        checkOutput("start_enter_run", 7'd1, 6'd2, 1, 0, 0, 0);
        applyStimulus(C_NONE, 7'd0, 6'd0);
        checkOutput("tick_1_01", 7'd1, 6'd1, 1, 0, 0, 0);
        applyStimulus(C_NONE, 7'd0, 6'd0);
        checkOutput("tick_1_00", 7'd1, 6'd0, 1, 0, 0, 0);
        applyStimulus(C_NONE, 7'd0, 6'd0);
        checkOutput("tick_borrow_0_59", 7'd0, 6'd59, 1, 0, 0, 0);
        for (int i = 0; i < 58; i++) applyStimulus(C_NONE, 7'd0, 6'd0);
        checkOutput("tick_0_01", 7'd0, 6'd1, 1, 0, 0, 0);
        applyStimulus(C_NONE, 7'd0, 6'd0);
        checkOutput("expire_pulse", 7'd0, 6'd0, 0, 0, 1, 1);
        applyStimulus(C_NONE, 7'd0, 6'd0);
        checkOutput("alarm_cycle2", 7'd0, 6'd0, 0, 0, 0, 1);
        applyStimulus(C_NONE, 7'd0, 6'd0);
        checkOutput("alarm_cycle3", 7'd0, 6'd0, 0, 0, 0, 1);
        applyStimulus(C_NONE, 7'd0, 6'd0);
        checkOutput("alarm_over_idle", 7'd0, 6'd0, 0, 0, 0, 0);

        applyStimulus(C_LOAD, 7'd120, 6'd63);
        checkOutput("load_saturate_99_59", 7'd99, 6'd59, 0, 0, 0, 0);
        applyStimulus(C_INC, 7'd0, 6'd0);
        checkOutput("inc_saturate", 7'd99, 6'd59, 0, 0, 0, 0);

        applyStimulus(C_LOAD, 7'd0, 6'd45);
        applyStimulus(C_INC, 7'd0, 6'd0);
        checkOutput("inc_carry_1_15", 7'd1, 6'd15, 0, 0, 0, 0);
        applyStimulus(C_DEC, 7'd0, 6'd0);
        checkOutput("dec_borrow_0_45", 7'd0, 6'd45, 0, 0, 0, 0);

        applyStimulus(C_LOAD, 7'd0, 6'd20);
        applyStimulus(C_START, 7'd0, 6'd0);
        applyStimulus(C_PAUSE, 7'd0, 6'd0);
        checkOutput("pause_at_0_20", 7'd0, 6'd20, 0, 1, 0, 0);
        applyStimulus(C_DEC, 7'd0, 6'd0);
        checkOutput("pause_dec_floor_idle", 7'd0, 6'd0, 0, 0, 0, 0);

        applyStimulus(C_LOAD, 7'd2, 6'd11);
        applyStimulus(C_START, 7'd0, 6'd0);
        applyStimulus(C_NONE, 7'd0, 6'd0);
        checkOutput("run_2_10", 7'd2, 6'd10, 1, 0, 0, 0);
        applyStimulus(C_PAUSE, 7'd0, 6'd0);
        for (int i = 0; i < 4; i++) applyStimulus(C_NONE, 7'd0, 6'd0);
        checkOutput("pause_hold_2_10", 7'd2, 6'd10, 0, 1, 0, 0);
        applyStimulus(C_START, 7'd0, 6'd0);
        checkOutput("resume_2_10", 7'd2, 6'd10, 1, 0, 0, 0);
        applyStimulus(C_NONE, 7'd0, 6'd0);
        checkOutput("resume_tick_2_09", 7'd2, 6'd9, 1, 0, 0, 0);

        applyStimulus(C_CANCEL | C_START, 7'd0, 6'd0);
        checkOutput("cancel_over_start", 7'd0, 6'd0, 0, 0, 0, 0);
        applyStimulus(C_CANCEL | C_LOAD, 7'd5, 6'd5);
        checkOutput("cancel_over_load", 7'd0, 6'd0, 0, 0, 0, 0);

        applyStimulus(C_LOAD, 7'd0, 6'd25);
        applyStimulus(C_START, 7'd0, 6'd0);
        applyStimulus(C_DEC, 7'd0, 6'd0);
        checkOutput("run_dec_to_done", 7'd0, 6'd0, 0, 0, 1, 1);
        applyStimulus(C_START, 7'd0, 6'd0);
        checkOutput("start_ends_alarm", 7'd0, 6'd0, 0, 0, 0, 0);

        applyStimulus(C_LOAD, 7'd0, 6'd40);
        applyStimulus(C_START, 7'd0, 6'd0);
        applyStimulus(C_INC, 7'd0, 6'd0);
        checkOutput("run_inc_1_10", 7'd1, 6'd10, 1, 0, 0, 0);
        applyStimulus(C_NONE, 7'd0, 6'd0);
        checkOutput("run_tick_1_09", 7'd1, 6'd9, 1, 0, 0, 0);

        #2 rst = 1'b0;
        #1;
        checkOutput("async_reset_mid_run", 7'd0, 6'd0, 0, 0, 0, 0);
        #1 rst = 1'b1;
        applyStimulus(C_NONE, 7'd0, 6'd0);
        checkOutput("after_reset_idle", 7'd0, 6'd0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
